// File: rtl/mma_csr.sv
// mma_csr -- ICB-slave register block for the matrix-multiply-accumulate engine.
//
// Holds every GEMM parameter register and drives them as static levels into the
// MMA top level. A software START write becomes a one-cycle calc_start pulse; a
// small FSM then tracks the run through sa_ready and raises DONE / irq.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   icb_cmd_*                  command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*                  response channel (valid/ready/rdata/err), registered
//   calc_start                 one-cycle start pulse to the engine
//   sa_ready                   engine idle/ready level
//   irq                        completion interrupt (DONE & IRQ_EN), registered
//   lhs_base .. act_max        config register levels (word offsets 0x08..0x50)
//   use_per_channel            CTRL.PER_CH
module mma_csr #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   icb_cmd_valid,
    output logic                   icb_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  icb_cmd_addr,
    input  logic                   icb_cmd_read,
    input  logic [REG_WIDTH-1:0]   icb_cmd_wdata,
    input  logic [REG_WIDTH/8-1:0] icb_cmd_wmask,
    output logic                   icb_rsp_valid,
    input  logic                   icb_rsp_ready,
    output logic [REG_WIDTH-1:0]   icb_rsp_rdata,
    output logic                   icb_rsp_err,
    output logic                   calc_start,
    input  logic                   sa_ready,
    output logic                   irq,
    output logic [REG_WIDTH-1:0]   lhs_base,
    output logic [REG_WIDTH-1:0]   rhs_base,
    output logic [REG_WIDTH-1:0]   dst_base,
    output logic [REG_WIDTH-1:0]   bias_base,
    output logic [REG_WIDTH-1:0]   ksum_base,
    output logic [REG_WIDTH-1:0]   lhs_zp,
    output logic [REG_WIDTH-1:0]   dst_zp,
    output logic [REG_WIDTH-1:0]   q_mult_pt,
    output logic [REG_WIDTH-1:0]   q_shift_pt,
    output logic [REG_WIDTH-1:0]   q_mult_pc_base,
    output logic [REG_WIDTH-1:0]   q_shift_pc_base,
    output logic [REG_WIDTH-1:0]   k,
    output logic [REG_WIDTH-1:0]   n,
    output logic [REG_WIDTH-1:0]   m,
    output logic [REG_WIDTH-1:0]   lhs_row_stride_b,
    output logic [REG_WIDTH-1:0]   dst_row_stride_b,
    output logic [REG_WIDTH-1:0]   rhs_row_stride_b,
    output logic [REG_WIDTH-1:0]   act_min,
    output logic [REG_WIDTH-1:0]   act_max,
    output logic                   use_per_channel
);
    localparam int NB   = REG_WIDTH / 8;
    localparam int IDXW = ADDR_WIDTH - 2;
    localparam int NCFG = 19;   // word offsets 2..20

    localparam logic [REG_WIDTH-1:0] ACT_MIN_RST = {{(REG_WIDTH-8){1'b1}}, 8'h80};
    localparam logic [REG_WIDTH-1:0] ACT_MAX_RST = {{(REG_WIDTH-8){1'b0}}, 8'h7F};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [REG_WIDTH-1:0] cfg_q [NCFG];
    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 per_ch_q, irq_en_q, done_q, start_err_q, irq_q;
    logic                 rsp_valid_q, err_q;
    logic [REG_WIDTH-1:0] rdata_q;

    logic [IDXW-1:0]      idx;
    logic                 cmd_fire, wr, busy, is_ctrl, is_stat, is_cfg, mapped;
    logic                 start_req, start_ok, ctrl_wr, cfg_wr, done_set, done_clr, serr_clr;
    logic                 err_d;
    logic [REG_WIDTH-1:0] rdata_d;
    logic                 unused_addr_lsb;

    // Byte-granular merge of write data into an existing register value.
    function automatic logic [REG_WIDTH-1:0] bmerge(input logic [REG_WIDTH-1:0] old,
                                                    input logic [REG_WIDTH-1:0] wd,
                                                    input logic [NB-1:0]        wm);
        bmerge = old;
        for (int b = 0; b < NB; b++)
            if (wm[b]) bmerge[b*8 +: 8] = wd[b*8 +: 8];
    endfunction

    assign unused_addr_lsb = ^icb_cmd_addr[1:0];
    assign idx       = icb_cmd_addr[ADDR_WIDTH-1:2];
    assign is_ctrl   = (idx == IDXW'(0));
    assign is_stat   = (idx == IDXW'(1));
    assign is_cfg    = (idx >= IDXW'(2)) && (idx <= IDXW'(20));
    assign mapped    = is_ctrl | is_stat | is_cfg;
    assign busy      = (state_q != S_IDLE);

    assign icb_cmd_ready = ~rsp_valid_q;
    assign cmd_fire  = icb_cmd_valid & icb_cmd_ready;
    assign wr        = cmd_fire & ~icb_cmd_read;
    assign start_req = wr & is_ctrl & icb_cmd_wmask[0] & icb_cmd_wdata[0];
    assign start_ok  = start_req & ~busy & sa_ready;
    // Config (and CTRL mode bits) are frozen while a job is in flight.
    assign ctrl_wr   = wr & is_ctrl & icb_cmd_wmask[0] & ~busy;
    assign cfg_wr    = wr & is_cfg & ~busy;
    assign done_clr  = wr & is_stat & icb_cmd_wmask[0] & icb_cmd_wdata[1];
    assign serr_clr  = wr & is_stat & icb_cmd_wmask[0] & icb_cmd_wdata[2];

    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (!mapped) begin
            err_d = 1'b1;
        end else if (icb_cmd_read) begin
            if (is_ctrl) rdata_d[2:0] = {irq_en_q, per_ch_q, 1'b0};   // START reads 0
            if (is_stat) rdata_d[2:0] = {start_err_q, done_q, busy};
            for (int i = 0; i < NCFG; i++)
                if (idx == IDXW'(i + 2)) rdata_d = cfg_q[i];
        end else begin
            if (is_cfg && busy) err_d = 1'b1;
            if (is_ctrl && icb_cmd_wmask[0] && (busy || (icb_cmd_wdata[0] && !sa_ready)))
                err_d = 1'b1;
        end
    end

    // Run tracker. WAIT gives the engine 16 cycles to drop sa_ready; if it never
    // does, the job is taken to be zero-work and completes immediately.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_PULSE;
            S_PULSE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (!sa_ready) begin
                    state_d = S_RUN;
                end else if (cnt_q == 4'd15) begin
                    state_d  = S_IDLE;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: if (sa_ready) begin
                state_d  = S_IDLE;
                done_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            per_ch_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (ctrl_wr) begin
                per_ch_q <= icb_cmd_wdata[1];
                irq_en_q <= icb_cmd_wdata[2];
            end
            // Set wins over a simultaneous W1C.
            done_q      <= done_set | (done_q & ~done_clr);
            start_err_q <= (start_req & ~start_ok) | (start_err_q & ~serr_clr);
            irq_q       <= done_q & irq_en_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCFG; i++) cfg_q[i] <= '0;
            cfg_q[17] <= ACT_MIN_RST;
            cfg_q[18] <= ACT_MAX_RST;
        end else begin
            for (int i = 0; i < NCFG; i++)
                if (cfg_wr && idx == IDXW'(i + 2))
                    cfg_q[i] <= bmerge(cfg_q[i], icb_cmd_wdata, icb_cmd_wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (cmd_fire) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end else if (icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign icb_rsp_valid    = rsp_valid_q;
    assign icb_rsp_rdata    = rdata_q;
    assign icb_rsp_err      = err_q;
    assign calc_start       = (state_q == S_PULSE);
    assign irq              = irq_q;
    assign use_per_channel  = per_ch_q;

    assign lhs_base         = cfg_q[0];
    assign rhs_base         = cfg_q[1];
    assign dst_base         = cfg_q[2];
    assign bias_base        = cfg_q[3];
    assign ksum_base        = cfg_q[4];
    assign lhs_zp           = cfg_q[5];
    assign dst_zp           = cfg_q[6];
    assign q_mult_pt        = cfg_q[7];
    assign q_shift_pt       = cfg_q[8];
    assign q_mult_pc_base   = cfg_q[9];
    assign q_shift_pc_base  = cfg_q[10];
    assign k                = cfg_q[11];
    assign n                = cfg_q[12];
    assign m                = cfg_q[13];
    assign lhs_row_stride_b = cfg_q[14];
    assign dst_row_stride_b = cfg_q[15];
    assign rhs_row_stride_b = cfg_q[16];
    assign act_min          = cfg_q[17];
    assign act_max          = cfg_q[18];
endmodule

// File: tb/tb_mma_csr.sv
// Bench for mma_csr: random register traffic against a word-level register
// model, plus directed start/run, busy-protection, timeout, backpressure and
// mid-run reset scenarios.
module tb_mma_csr;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [7:0]  icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        calc_start, sa_ready, irq, use_per_channel;
    logic [31:0] lhs_base, rhs_base, dst_base, bias_base, ksum_base, lhs_zp, dst_zp;
    logic [31:0] q_mult_pt, q_shift_pt, q_mult_pc_base, q_shift_pc_base, k, n, m;
    logic [31:0] lhs_row_stride_b, dst_row_stride_b, rhs_row_stride_b, act_min, act_max;

    always #5 clk = ~clk;

    mma_csr dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .calc_start(calc_start), .sa_ready(sa_ready), .irq(irq),
        .lhs_base(lhs_base), .rhs_base(rhs_base), .dst_base(dst_base),
        .bias_base(bias_base), .ksum_base(ksum_base), .lhs_zp(lhs_zp), .dst_zp(dst_zp),
        .q_mult_pt(q_mult_pt), .q_shift_pt(q_shift_pt), .q_mult_pc_base(q_mult_pc_base),
        .q_shift_pc_base(q_shift_pc_base), .k(k), .n(n), .m(m),
        .lhs_row_stride_b(lhs_row_stride_b), .dst_row_stride_b(dst_row_stride_b),
        .rhs_row_stride_b(rhs_row_stride_b), .act_min(act_min), .act_max(act_max),
        .use_per_channel(use_per_channel)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, pulse_cnt = 0, pulse_cyc = 0;

    // Reference model: one word per register plus the control/status flags.
    logic [31:0] m_cfg [2:20];
    logic        m_pch, m_ien, m_done, m_serr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (calc_start === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
    end

    task automatic m_reset();
        for (int i = 2; i <= 20; i++) m_cfg[i] = 32'h0;
        m_cfg[19] = 32'hFFFF_FF80;
        m_cfg[20] = 32'h0000_007F;
        m_pch = 0; m_ien = 0; m_done = 0; m_serr = 0;
    endtask

    // Returns {err, rdata} for a read of word idx.
    function automatic logic [32:0] m_rd(input int idx, input bit busy);
        if (idx == 0)       return {1'b0, 29'd0, m_ien, m_pch, 1'b0};
        else if (idx == 1)  return {1'b0, 29'd0, m_serr, m_done, busy};
        else if (idx <= 20) return {1'b0, m_cfg[idx]};
        else                return {1'b1, 32'd0};
    endfunction

    task automatic m_write(input int idx, input logic [31:0] wd, input logic [3:0] wm,
                           input bit busy, output logic e);
        e = 0;
        if (idx > 20) e = 1;
        else if (idx == 0) begin
            if (wm[0]) begin
                if (busy) begin
                    e = 1;
                    if (wd[0]) m_serr = 1;
                end else begin
                    m_pch = wd[1];
                    m_ien = wd[2];
                    if (wd[0] && !sa_ready) begin e = 1; m_serr = 1; end
                end
            end
        end else if (idx == 1) begin
            if (wm[0] && wd[1]) m_done = 0;
            if (wm[0] && wd[2]) m_serr = 0;
        end else if (busy) e = 1;
        else for (int b = 0; b < 4; b++)
            if (wm[b]) m_cfg[idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    function automatic logic [31:0] cfg_port(input int idx);
        case (idx)
            2: return lhs_base;          3: return rhs_base;
            4: return dst_base;          5: return bias_base;
            6: return ksum_base;         7: return lhs_zp;
            8: return dst_zp;            9: return q_mult_pt;
            10: return q_shift_pt;       11: return q_mult_pc_base;
            12: return q_shift_pc_base;  13: return k;
            14: return n;                15: return m;
            16: return lhs_row_stride_b; 17: return dst_row_stride_b;
            18: return rhs_row_stride_b; 19: return act_min;
            default: return act_max;
        endcase
    endfunction

    task automatic bus(input bit rd, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, output logic [31:0] rdata, output logic err);
        int w = 0;
        @(negedge clk);
        while (!icb_cmd_ready && w < 50) begin @(negedge clk); w++; end
        if (!icb_cmd_ready) chk("cmd_ready_timeout", 32'(icb_cmd_ready), 32'd1);
        icb_cmd_valid = 1; icb_cmd_read = rd; icb_cmd_addr = addr;
        icb_cmd_wdata = wd; icb_cmd_wmask = wm;
        @(posedge clk); #1 icb_cmd_valid = 0;
        w = 0;
        while (!icb_rsp_valid && w < 50) begin @(negedge clk); w++; end
        if (!icb_rsp_valid) chk("rsp_timeout", 32'(icb_rsp_valid), 32'd1);
        rdata = icb_rsp_rdata;
        err   = icb_rsp_err;
        if (icb_rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic do_rd(input int idx, input bit busy, input string tag);
        logic [31:0] d; logic e; logic [32:0] x;
        x = m_rd(idx, busy);
        bus(1, 8'(idx * 4 + $urandom_range(0, 3)), $urandom, 4'hF, d, e);
        chk({tag, "_data"}, d, x[31:0]);
        chk({tag, "_err"}, 32'(e), 32'(x[32]));
    endtask

    task automatic do_wr(input int idx, input logic [31:0] wd, input logic [3:0] wm,
                         input bit busy, input string tag);
        logic [31:0] d; logic e, xe;
        m_write(idx, wd, wm, busy, xe);
        bus(0, 8'(idx * 4), wd, wm, d, e);
        chk({tag, "_err"}, 32'(e), 32'(xe));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdv, wd;
        logic        e;
        int          p0, t0, idx;
        icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0;
        icb_cmd_wdata = 0; icb_cmd_wmask = 0; icb_rsp_ready = 1; sa_ready = 1;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("rst_act_min", act_min, 32'hFFFF_FF80);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1;

        // Reset contents of every mapped word plus the first unmapped one.
        for (int i = 0; i <= 21; i++) do_rd(i, 0, "rst_rd");

        // Byte masking on k.
        do_wr(13, 32'hAABB_CCDD, 4'b0101, 0, "mask_wr");
        chk("mask_k_port", k, 32'h00BB_00DD);
        do_rd(13, 0, "mask_rd");

        // Random register traffic while idle (START bit never set here).
        for (int it = 0; it < 120; it++) begin
            idx = $urandom_range(0, 23);
            if ($urandom_range(0, 1) == 0) begin
                do_rd(idx, 0, "rnd_rd");
            end else begin
                wd = $urandom;
                if (idx == 0) wd[0] = 1'b0;
                do_wr(idx, wd, 4'($urandom_range(0, 15)), 0, "rnd_wr");
                if (idx >= 2 && idx <= 20) chk("rnd_port", cfg_port(idx), m_cfg[idx]);
                chk("rnd_per_ch", 32'(use_per_channel), 32'(m_pch));
            end
        end

        // Start and run, with busy protection during RUN.
        do_wr(1, 32'h6, 4'hF, 0, "clr_status");
        sa_ready = 1;
        p0 = pulse_cnt;
        do_wr(0, 32'h5, 4'h1, 0, "start_wr");
        chk("start_pulse", 32'(pulse_cnt), 32'(p0 + 1));
        @(negedge clk); sa_ready = 0;
        do_rd(1, 1, "run_status");
        do_wr(14, 32'd5, 4'hF, 1, "busy_cfg_wr");
        chk("busy_n_port", n, m_cfg[14]);
        do_wr(0, 32'h1, 4'h1, 1, "busy_start");
        do_rd(1, 1, "busy_status");
        chk("busy_no_pulse", 32'(pulse_cnt), 32'(p0 + 1));
        chk("run_irq", 32'(irq), 32'd0);
        repeat (30) @(negedge clk);
        sa_ready = 1;
        @(negedge clk);
        chk("irq_lag", 32'(irq), 32'd0);
        m_done = 1;
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        do_rd(1, 0, "done_status");
        do_wr(1, 32'h2, 4'h1, 0, "w1c_done");
        repeat (2) @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);
        do_rd(1, 0, "after_w1c");
        do_wr(1, 32'h4, 4'h1, 0, "w1c_serr");

        // Zero-work: sa_ready never drops, job times out into DONE.
        do_wr(0, 32'h1, 4'h1, 0, "zw_start");
        t0 = pulse_cyc;
        chk("zw_pulse", 32'(pulse_cnt), 32'(p0 + 2));
        while (cyc < t0 + 12) @(negedge clk);
        do_rd(1, 1, "zw_busy");
        while (cyc < t0 + 24) @(negedge clk);
        m_done = 1;
        do_rd(1, 0, "zw_done");
        chk("zw_irq", 32'(irq), 32'd0);
        chk("zw_per_ch", 32'(use_per_channel), 32'd0);

        // Backpressure: response held, cmd_ready low, rdata stable.
        icb_rsp_ready = 0;
        @(negedge clk);
        icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = 8'h38;
        @(posedge clk); #1 icb_cmd_valid = 0;
        rdv = icb_rsp_rdata;
        chk("bp_rdata0", rdv, m_cfg[14]);
        repeat (5) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(icb_cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(icb_rsp_valid), 32'd1);
            chk("bp_rdata", icb_rsp_rdata, m_cfg[14]);
        end
        icb_rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_release", 32'(icb_rsp_valid), 32'd0);

        // Reset mid-run with DONE still pending and IRQ_EN on, response outstanding.
        do_wr(0, 32'h5, 4'h1, 0, "rr_start");
        @(negedge clk); sa_ready = 0;
        repeat (5) @(negedge clk);
        chk("rr_irq_pre", 32'(irq), 32'd1);
        icb_rsp_ready = 0;
        icb_cmd_valid = 1; icb_cmd_read = 1; icb_cmd_addr = 8'h04;
        @(posedge clk); #1 icb_cmd_valid = 0;
        chk("rr_rsp_pre", 32'(icb_rsp_valid), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rr_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("rr_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("rr_irq", 32'(irq), 32'd0);
        chk("rr_calc_start", 32'(calc_start), 32'd0);
        chk("rr_k", k, 32'd0);
        chk("rr_act_max", act_max, 32'h7F);
        chk("rr_per_ch", 32'(use_per_channel), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1; icb_rsp_ready = 1; sa_ready = 1;
        do_rd(1, 0, "rr_status");
        do_rd(0, 0, "rr_ctrl");
        repeat (20) @(negedge clk);
        do_rd(1, 0, "rr_no_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
